// File: rtl/bus_arbiter_if.sv
// Bus signal bundle for bus_arbiter: active-low per-master request/grant plus owner status.
// The arbiter connects through the slave modport; requesters use the master modport.
interface bus_arbiter_if;
  logic [3:0] Req_;
  logic [3:0] Grnt_;
  logic [1:0] Owner;
  logic       Busy;
  logic       TimeoutEvt;

  modport master (output Req_, input Grnt_, Owner, Busy, TimeoutEvt);
  modport slave  (input Req_, output Grnt_, Owner, Busy, TimeoutEvt);
endinterface

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with a one-cycle turnaround between owners.
// Optional ownership timeout and revoke mask are built when BUS_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no grant; arbitrate among eligible requesters starting at ptr
// GRANT | exactly one master owns the bus until it releases (or is revoked)
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state, state_next;
  logic [1:0] owner, owner_next;
  logic [1:0] ptr, ptr_next;
  logic [3:0] req;
  logic [3:0] eligible;
  logic       owner_req;
  logic       found;
  logic [1:0] pick;
  logic [1:0] idx;

  assign req       = ~bus.Req_;
  assign owner_req = req[owner];

`ifdef BUS_ARB_TIMEOUT_EN
  logic [15:0] cnt, cnt_next;
  logic [3:0]  mask, mask_next;
  logic        evt, evt_next;
  logic        expire;

  assign eligible = req & ~mask;
  assign expire   = (cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cycles;

  assign eligible              = req;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES > 0);
`endif

  // First eligible requester at or after ptr, wrapping 3 -> 0.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr   <= 2'd0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt   <= 16'd0;
      mask  <= 4'b0000;
      evt   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      owner <= owner_next;
      ptr   <= ptr_next;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt   <= cnt_next;
      mask  <= mask_next;
      evt   <= evt_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    ptr_next   = ptr;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_next   = cnt;
    // A masked master regains eligibility once it is seen not requesting.
    mask_next  = mask & ~bus.Req_;
    evt_next   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_next = GRANT;
          owner_next = pick;
          ptr_next   = pick + 2'd1;
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_next   = 16'd0;
`endif
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_next = IDLE;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (expire) begin
          state_next       = IDLE;
          mask_next[owner] = 1'b1;
          evt_next         = 1'b1;
        end else begin
          cnt_next = cnt + 16'd1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.Grnt_ = 4'b1111;
    if (state == GRANT) begin
      bus.Grnt_[owner] = 1'b0;
    end
    bus.Owner = owner;
    bus.Busy  = (state == GRANT);
`ifdef BUS_ARB_TIMEOUT_EN
    bus.TimeoutEvt = evt;
`else
    bus.TimeoutEvt = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a driver feeds Req_/reset and a round-robin reference
// model queues the expected outputs; a monitor pops and compares one entry per cycle.
module tb_bus_arbiter;

  localparam int TO = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] grnt;
    logic [1:0] owner;
    logic       busy;
    logic       evt;
    logic       chk_owner;
  } exp_t;

  logic clk;
  logic reset;
  bus_arbiter_if bus ();

  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   glog[$];
  int   errors = 0;
  int   checks = 0;
  int   evt_seen = 0;
  int   busy_cycles = 0;

  // reference model: owner index (-1 = none), pointer, cycles held, revoke mask
  int       m_owner = -1;
  int       m_ptr = 0;
  int       m_held = 0;
  bit [3:0] m_mask = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int get_log(input int k);
    if (k < glog.size()) return glog[k];
    return 99;
  endfunction

  function automatic void model_step(input logic r, input logic [3:0] rq);
    exp_t e;
    int   i;
    bit   evt;
    evt = 1'b0;
    e.chk_owner = 1'b0;
    if (r) begin
      m_owner = -1;
      m_ptr = 0;
      m_held = 0;
      m_mask = '0;
      e.chk_owner = 1'b1;
    end else begin
      if (m_owner < 0) begin
        for (int k = 0; k < 4; k++) begin
          i = (m_ptr + k) % 4;
          if (m_owner < 0 && !rq[i] && !m_mask[i]) begin
            m_owner = i;
            m_ptr = (i + 1) % 4;
            m_held = 1;
          end
        end
      end else if (rq[m_owner]) begin
        m_owner = -1;
      end else if (TO_EN && m_held == TO) begin
        m_mask[m_owner] = 1'b1;
        m_owner = -1;
        evt = 1'b1;
      end else begin
        m_held++;
      end
      m_mask = m_mask & ~rq;
    end
    e.busy  = (m_owner >= 0);
    e.grnt  = e.busy ? ~(4'b0001 << m_owner) : 4'b1111;
    e.owner = e.busy ? 2'(m_owner) : 2'd0;
    if (e.busy) e.chk_owner = 1'b1;
    e.evt = evt;
    sb.push_back(e);
  endfunction

  task automatic step(input logic r, input logic [3:0] rq);
    @(negedge clk);
    reset = r;
    bus.Req_ = rq;
    model_step(r, rq);
  endtask

  // monitor
  initial begin
    exp_t e;
    logic       prev_busy;
    logic [1:0] prev_owner;
    prev_busy = 1'b0;
    prev_owner = 2'd0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("grnt", 32'(bus.Grnt_), 32'(e.grnt));
        chk("busy", 32'(bus.Busy), 32'(e.busy));
        chk("timeout_evt", 32'(bus.TimeoutEvt), 32'(e.evt));
        if (e.chk_owner) chk("owner", 32'(bus.Owner), 32'(e.owner));
        chk("one_cold", 32'($countones(~bus.Grnt_) <= 1), 32'd1);
        chk("busy_vs_grnt", 32'(bus.Busy), 32'(bus.Grnt_ != 4'b1111));
        if (bus.Busy) chk("owner_vs_grnt", 32'(bus.Grnt_[bus.Owner]), 32'd0);
        if (prev_busy && bus.Busy) chk("no_preempt", 32'(bus.Owner), 32'(prev_owner));
        if (bus.Busy && !prev_busy) glog.push_back(int'(bus.Owner));
        if (bus.TimeoutEvt) evt_seen++;
        if (bus.Busy) busy_cycles++;
        prev_busy = bus.Busy;
        prev_owner = bus.Owner;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rq;
    logic       r;
    clk = 1'b0;
    reset = 1'b1;
    bus.Req_ = 4'b1111;

    // reset holds everything idle even with all requests active
    step(1, 4'b1111);
    step(1, 4'b0000);

    // single request from master 0, then pointer moved to 1
    glog.delete();
    step(0, 4'b1110);
    step(0, 4'b1110);
    step(0, 4'b1111);
    step(0, 4'b1111);
    step(0, 4'b1100);
    step(0, 4'b1100);
    step(0, 4'b1111);
    chk("first_grant_m0", get_log(0), 0);
    chk("ptr_after_m0", get_log(1), 1);

    // all requesting, each owner releases after three grant cycles
    step(1, 4'b1111);
    glog.delete();
    for (int c = 0; c < 22; c++) begin
      rq = 4'b0000;
      if (m_owner >= 0 && m_held >= 3) rq[m_owner] = 1'b1;
      step(0, rq);
    end
    step(0, 4'b1111);
    for (int k = 0; k < 5; k++) chk("rr_order", get_log(k), k % 4);

    // master 2 requests and withdraws while master 1 owns: no trace
    step(1, 4'b1111);
    glog.delete();
    step(0, 4'b1101);
    step(0, 4'b1101);
    repeat (5) step(0, 4'b1001);
    repeat (2) step(0, 4'b1101);
    repeat (4) step(0, 4'b1111);
    chk("withdraw_grants", glog.size(), 1);
    chk("withdraw_owner", get_log(0), 1);

    // reset while master 3 owns; pointer returns to 0 so master 1 beats master 2
    step(1, 4'b1111);
    step(0, 4'b0111);
    repeat (3) step(0, 4'b0111);
    glog.delete();
    step(1, 4'b1001);
    step(0, 4'b1001);
    step(0, 4'b1001);
    step(0, 4'b1111);
    chk("post_reset_owner", get_log(0), 1);

`ifdef BUS_ARB_TIMEOUT_EN
    // continuous request from master 0 is revoked after TO cycles and stays masked
    step(1, 4'b1111);
    glog.delete();
    evt_seen = 0;
    busy_cycles = 0;
    repeat (9) step(0, 4'b1110);
    chk("to_grant_cycles", busy_cycles, TO);
    chk("to_evt_pulses", evt_seen, 1);
    chk("to_masked", glog.size(), 1);
    step(0, 4'b1111);
    repeat (3) step(0, 4'b1110);
    step(0, 4'b1111);
    chk("to_regrant", glog.size(), 2);
    chk("to_regrant_owner", get_log(1), 0);
`endif

    // randomized traffic with occasional resets
    step(1, 4'b1111);
    rq = 4'b1111;
    for (int c = 0; c < 10000; c++) begin
      r = ($urandom_range(0, 199) == 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
      end
      step(r, rq);
    end
    step(0, 4'b1111);
    step(0, 4'b1111);
    @(posedge clk);
    #2;
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
